alu_req_arbiter: RTL and testbench
==================================

# alu_req_arbiter

Two-requester scheduler for the shared 8-bit `ALU`. It arbitrates round-robin between two request ports, issues exactly one single-cycle one-hot operation strobe per accepted request, and captures the registered result and flags from the `ALU`. It returns them to the winning requester over a valid/ready response channel. It sits between the sequencer/register-file requesters and the `ALU` instance, and is the only block driving the `ALU` strobes.

## Interface
- `RR_INIT`, 1'b1: reset value of the last-grant register. The default gives requester 0 first priority.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request pending.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_op` / `req1_op`  in  2  00 add, 01 sub, 10 inc, 11 dec.
- `req0_x`, `req0_y` / `req1_x`, `req1_y`  in  8  operands. `y` is ignored for inc and dec.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_id`  out  1  index of the requester that owns the result.
- `resp_data`  out  8  result byte.
- `resp_flags`  out  5  {CF, AF, ZF, SF, OF}.
- `alu_add`, `alu_sub`, `alu_inc`, `alu_dec`  out  1 each  one-hot operation strobes to the `ALU`.
- `alu_x`, `alu_y`  out  8  operands to the `ALU`.
- `alu_b`  in  8  registered `ALU` result.
- `alu_cf`, `alu_af`, `alu_zf`, `alu_sf`, `alu_of`  in  1 each  registered `ALU` flags.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Encoded state plus a `last_grant` bit.
- IDLE, grant selection:
  - If one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester ≠ `last_grant` is granted.
- IDLE, handshake:
  - `reqN_ready` = (state == IDLE) && grant == N. This is combinational from the valids.
  - On valid&&ready, latch op, x, y and id, set `last_grant` = id, and go to ISSUE.
- Requester rules:
  - A requester must hold valid, op and operands stable until ready.
  - A requester must not deassert valid before acceptance. Doing so is a protocol violation with undefined results.
- ISSUE (one cycle):
  - Drive `alu_x` / `alu_y` from the latches.
  - Assert exactly the one strobe decoded from the latched op.
  - Then go to WAIT.
- WAIT (one cycle):
  - The `ALU` outputs now reflect the issued operation.
  - At the end of the cycle, register `alu_b` into `resp_data` and the five flags into `resp_flags`, then go to RESP.
- RESP:
  - `resp_valid` = 1. `resp_id`, `resp_data` and `resp_flags` stay stable while `resp_ready` = 0.
  - On `resp_ready` = 1, go to IDLE, or see Configuration for back-to-back operation.
- Strobes and operands:
  - All strobes are 0 outside ISSUE, so the `ALU` holds its outputs.
  - `alu_x` / `alu_y` hold the latched values in all states; they reset to 0.
- Arithmetic and flags are produced entirely by the `ALU`. This block never modifies them.
- Reset values: state IDLE, `last_grant` = `RR_INIT`, and all outputs 0 (`resp_valid`, `resp_id`, `resp_data`, `resp_flags`, strobes, `alu_x`, `alu_y`, `reqN_ready`).

## Timing
- Accept at edge E0, with ready high in the IDLE cycle before E0.
- ISSUE cycle is E0–E1, and the `ALU` samples its strobe at E1.
- WAIT cycle is E1–E2, and the response is captured at E2.
- `resp_valid` is high from E2. The minimum accept-to-`resp_valid` latency is 2 cycles.
- Throughput:
  - Default: one request per 4 cycles with `resp_ready` tied high.
  - With the macro below: one request per 3 cycles.
- Both requesters continuously valid: grants alternate 0, 1, 0, 1… (with `RR_INIT` = 1).
- A requester asserting valid during ISSUE, WAIT or RESP sees ready = 0 and waits. No request is dropped.
- Reset asserted mid-operation: everything clears asynchronously. A strobe in flight drops immediately, and no response is produced for the aborted request.

## Configuration
- `ALU_ARB_B2B_EN` defined:
  - In RESP with `resp_ready` = 1, arbitration runs in the same cycle (ready is asserted to the grant winner).
  - An accepted request goes directly to ISSUE, skipping IDLE.
- Not defined: RESP always returns to IDLE, and ready is never asserted outside IDLE.

## Test plan
- Reset, then req0 add x=8'h05 y=8'h03 -> `alu_add` pulses for exactly 1 cycle; `resp_valid` 2 cycles after accept with `resp_id`=0, `resp_data`=8'h08, `resp_flags`=5'b00000.
- req1 sub x=8'h10 y=8'h10 -> `alu_sub` single pulse; `resp_data`=8'h00, ZF=1, `resp_id`=1.
- Both requesters continuously valid (req0 inc x=8'h7F, req1 dec x=8'h80) -> grants alternate 0, 1, 0; req0 results `resp_data`=8'h80 with CF=OF=AF=SF=1; req1 results `resp_data`=8'h7F with CF=OF=AF=1, SF=0.
- `resp_ready` held low 5 cycles -> `resp_valid`, `resp_data` and `resp_flags` stable; both `reqN_ready`=0; no strobes asserted.
- `rst_n` dropped during WAIT -> all outputs 0 immediately; after release, the next req0 add 1+1 returns 8'h02 with no stale response.
- With `ALU_ARB_B2B_EN` and `resp_ready`=1 under back-to-back requests -> strobe pulses spaced exactly 3 cycles apart; without the macro, 4 cycles apart.

Source files
------------

// File: rtl/alu_req_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_req_arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface alu_req_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [1:0] req0_op;
  logic [7:0] req0_x;
  logic [7:0] req0_y;

  logic       req1_valid;
  logic       req1_ready;
  logic [1:0] req1_op;
  logic [7:0] req1_x;
  logic [7:0] req1_y;

  logic       resp_valid;
  logic       resp_ready;
  logic       resp_id;
  logic [7:0] resp_data;
  logic [4:0] resp_flags;

  logic       alu_add;
  logic       alu_sub;
  logic       alu_inc;
  logic       alu_dec;
  logic [7:0] alu_x;
  logic [7:0] alu_y;
  logic [7:0] alu_b;
  logic       alu_cf;
  logic       alu_af;
  logic       alu_zf;
  logic       alu_sf;
  logic       alu_of;

  modport slave (
    input  req0_valid, req0_op, req0_x, req0_y,
    input  req1_valid, req1_op, req1_x, req1_y,
    output req0_ready, req1_ready,
    input  resp_ready,
    output resp_valid, resp_id, resp_data, resp_flags,
    output alu_add, alu_sub, alu_inc, alu_dec, alu_x, alu_y,
    input  alu_b, alu_cf, alu_af, alu_zf, alu_sf, alu_of
  );

  modport master (
    output req0_valid, req0_op, req0_x, req0_y,
    output req1_valid, req1_op, req1_x, req1_y,
    input  req0_ready, req1_ready,
    output resp_ready,
    input  resp_valid, resp_id, resp_data, resp_flags,
    input  alu_add, alu_sub, alu_inc, alu_dec, alu_x, alu_y,
    output alu_b, alu_cf, alu_af, alu_zf, alu_sf, alu_of
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin scheduler for two requesters sharing one registered 8-bit ALU.
// Define ALU_ARB_B2B_EN to let RESP accept the next request in the same cycle.
module alu_req_arbiter #(
  parameter logic RR_INIT = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  alu_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       id_q, id_d;
  logic [3:0] strobe_q, strobe_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_id_q, resp_id_d;
  logic [7:0] resp_data_q, resp_data_d;
  logic [4:0] resp_flags_q, resp_flags_d;

  logic       grant;
  logic       accept_window;
  logic       accept;
  logic [1:0] win_op;

  // A contested cycle goes to whoever was not served last.
  always_comb begin
    grant = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
`ifdef ALU_ARB_B2B_EN
    accept_window = (state_q == IDLE) || ((state_q == RESP) && bus.resp_ready);
`else
    accept_window = (state_q == IDLE);
`endif
    accept = accept_window && (bus.req0_valid || bus.req1_valid);
    win_op = grant ? bus.req1_op : bus.req0_op;
  end

  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    x_d          = x_q;
    y_d          = y_q;
    strobe_d     = 4'b0000;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_flags_d = resp_flags_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_id_d    = id_q;
        resp_data_d  = bus.alu_b;
        resp_flags_d = {bus.alu_cf, bus.alu_af, bus.alu_zf, bus.alu_sf, bus.alu_of};
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The op is held as its one-hot strobe, which fires only in the ISSUE cycle.
    if (accept) begin
      state_d      = ISSUE;
      last_grant_d = grant;
      id_d         = grant;
      x_d          = grant ? bus.req1_x : bus.req0_x;
      y_d          = grant ? bus.req1_y : bus.req0_y;
      strobe_d     = 4'b0001 << win_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= RR_INIT;
      id_q         <= 1'b0;
      x_q          <= 8'h00;
      y_q          <= 8'h00;
      strobe_q     <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= 8'h00;
      resp_flags_q <= 5'b00000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      x_q          <= x_d;
      y_q          <= y_d;
      strobe_q     <= strobe_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_flags_q <= resp_flags_d;
    end
  end

  assign bus.alu_add    = strobe_q[0];
  assign bus.alu_sub    = strobe_q[1];
  assign bus.alu_inc    = strobe_q[2];
  assign bus.alu_dec    = strobe_q[3];
  assign bus.alu_x      = x_q;
  assign bus.alu_y      = y_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_flags = resp_flags_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: stand-in registered ALU, a timestamp-based reference
// model compared every cycle, a directed vector table, corner sequences and random traffic.
`timescale 1ns/1ps
module tb_alu_req_arbiter;

`ifdef ALU_ARB_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_req_arbiter_if bus ();

  alu_req_arbiter #(.RR_INIT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference ALU behaviour returning {result, CF, AF, ZF, SF, OF}; inc/dec report carry into bit 7 as CF.
  function automatic logic [12:0] alu_fn(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] r;
    logic cf, af, of;
    r = 9'd0; cf = 1'b0; af = 1'b0; of = 1'b0;
    case (op)
      2'd0: begin
        r  = {1'b0, x} + {1'b0, y};
        cf = r[8];
        af = ({1'b0, x[3:0]} + {1'b0, y[3:0]}) > 5'd15;
        of = (x[7] == y[7]) && (r[7] != x[7]);
      end
      2'd1: begin
        r  = {1'b0, x} - {1'b0, y};
        cf = x < y;
        af = x[3:0] < y[3:0];
        of = (x[7] != y[7]) && (r[7] != x[7]);
      end
      2'd2: begin
        r  = {1'b0, x + 8'd1};
        cf = x[6:0] == 7'h7F;
        af = x[3:0] == 4'hF;
        of = x == 8'h7F;
      end
      default: begin
        r  = {1'b0, x - 8'd1};
        cf = x[6:0] == 7'h00;
        af = x[3:0] == 4'h0;
        of = x == 8'h80;
      end
    endcase
    return {r[7:0], cf, af, r[7:0] == 8'h00, r[7], of};
  endfunction

  logic [7:0] alu_b_r = 8'h00;
  logic [4:0] alu_f_r = 5'b00000;

  always @(posedge clk) begin
    if (bus.alu_add)      {alu_b_r, alu_f_r} <= alu_fn(2'd0, bus.alu_x, bus.alu_y);
    else if (bus.alu_sub) {alu_b_r, alu_f_r} <= alu_fn(2'd1, bus.alu_x, bus.alu_y);
    else if (bus.alu_inc) {alu_b_r, alu_f_r} <= alu_fn(2'd2, bus.alu_x, bus.alu_y);
    else if (bus.alu_dec) {alu_b_r, alu_f_r} <= alu_fn(2'd3, bus.alu_x, bus.alu_y);
  end

  assign bus.alu_b = alu_b_r;
  assign {bus.alu_cf, bus.alu_af, bus.alu_zf, bus.alu_sf, bus.alu_of} = alu_f_r;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [36:0] outs();
    return {bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id, bus.resp_data,
            bus.resp_flags, bus.alu_dec, bus.alu_inc, bus.alu_sub, bus.alu_add,
            bus.alu_x, bus.alu_y};
  endfunction

  // Model: a request accepted in cycle a strobes in a+1 and responds from a+3 until consumed.
  bit         m_active = 1'b0;
  int         m_acc    = 0;
  bit         m_last   = 1'b1;
  bit         m_id     = 1'b0;
  logic [1:0] m_op     = 2'd0;
  logic [7:0] m_x      = 8'h00;
  logic [7:0] m_y      = 8'h00;
  logic [12:0] m_res   = 13'd0;
  int         cyc      = 0;
  bit         acc0     = 1'b0;
  bit         acc1     = 1'b0;

  always @(negedge clk) begin
    logic [36:0] act, exp;
    bit v0, v1, rv, win, g, r0, r1;
    logic [3:0] stb;
    cyc++;
    if (!rst_n) begin
      m_active = 1'b0;
      m_last   = 1'b1;
      m_x      = 8'h00;
      m_y      = 8'h00;
      acc0     = 1'b0;
      acc1     = 1'b0;
    end else begin
      v0  = bus.req0_valid;
      v1  = bus.req1_valid;
      rv  = m_active && (cyc >= m_acc + 3);
      stb = (m_active && (cyc == m_acc + 1)) ? (4'b0001 << m_op) : 4'b0000;
      win = !m_active || (B2B && rv && bus.resp_ready);
      g   = (v0 && v1) ? !m_last : v1;
      r0  = win && v0 && !g;
      r1  = win && v1 && g;
      exp = {r0, r1, stb, rv, rv ? {m_id, m_res} : 14'd0, m_x, m_y};
      act = {bus.req0_ready, bus.req1_ready, bus.alu_dec, bus.alu_inc, bus.alu_sub, bus.alu_add,
             bus.resp_valid, rv ? {bus.resp_id, bus.resp_data, bus.resp_flags} : 14'd0,
             bus.alu_x, bus.alu_y};
      checkOutput($sformatf("model cycle %0d", cyc), 64'(act), 64'(exp));
      acc0 = r0;
      acc1 = r1;
      if (rv && bus.resp_ready) m_active = 1'b0;
      if (r0 || r1) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_last   = g;
        m_id     = g;
        m_op     = g ? bus.req1_op : bus.req0_op;
        m_x      = g ? bus.req1_x : bus.req0_x;
        m_y      = g ? bus.req1_y : bus.req0_y;
        m_res    = alu_fn(m_op, m_x, m_y);
      end
    end
  end

  typedef struct {
    bit         id;
    logic [1:0] op;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] exp_data;
    logic [4:0] exp_flags;
  } vec_t;

  task automatic waitReady(input bit id);
    int k;
    k = 0;
    @(negedge clk);
    while (!(id ? bus.req1_ready : bus.req0_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput($sformatf("req%0d accepted in time", id), 64'(k < 20), 64'd1);
  endtask

  task automatic waitResp();
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("response arrives in time", 64'(k < 20), 64'd1);
  endtask

  task automatic pulseReset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Issues one request, then measures strobe pulses and edges after E0 until resp_valid.
  task automatic applyStimulus(input vec_t v, output logic [7:0] data, output logic [4:0] flags,
                               output logic id, output int edges, output int pulses, output int stray);
    logic [3:0] s;
    @(posedge clk); #1;
    if (v.id) begin
      bus.req1_valid = 1'b1; bus.req1_op = v.op; bus.req1_x = v.x; bus.req1_y = v.y;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = v.op; bus.req0_x = v.x; bus.req0_y = v.y;
    end
    waitReady(v.id);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    data = 8'h00; flags = 5'b00000; id = 1'b0;
    edges = 0; pulses = 0; stray = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      edges++;
      s = {bus.alu_dec, bus.alu_inc, bus.alu_sub, bus.alu_add};
      if (s == (4'b0001 << v.op)) pulses++;
      else if (s != 4'b0000) stray++;
      if (bus.resp_valid) begin
        data  = bus.resp_data;
        flags = bus.resp_flags;
        id    = bus.resp_id;
        break;
      end
    end
    edges = edges - 1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    logic [7:0] d;
    logic [4:0] f;
    logic       rid;
    int e, p, s;
    int nr, ns;
    int stb_at[4];
    logic [13:0] got[3];
    logic cur, prev;

    vecs[0] = '{1'b0, 2'd0, 8'h05, 8'h03, 8'h08, 5'b00000};
    vecs[1] = '{1'b1, 2'd1, 8'h10, 8'h10, 8'h00, 5'b00100};
    vecs[2] = '{1'b0, 2'd0, 8'hFF, 8'h01, 8'h00, 5'b11100};
    vecs[3] = '{1'b1, 2'd1, 8'h00, 8'h01, 8'hFF, 5'b11010};
    vecs[4] = '{1'b0, 2'd0, 8'h7F, 8'h01, 8'h80, 5'b01011};
    vecs[5] = '{1'b1, 2'd2, 8'hFF, 8'hAA, 8'h00, 5'b11100};
    vecs[6] = '{1'b0, 2'd3, 8'h01, 8'h55, 8'h00, 5'b00100};
    vecs[7] = '{1'b1, 2'd2, 8'h7F, 8'h00, 8'h80, 5'b11011};

    bus.req0_valid = 1'b0; bus.req0_op = 2'd0; bus.req0_x = 8'h00; bus.req0_y = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_op = 2'd0; bus.req1_x = 8'h00; bus.req1_y = 8'h00;
    bus.resp_ready = 1'b1;
    #2;
    checkOutput("reset state", 64'(outs()), 64'd0);
    #15;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], d, f, rid, e, p, s);
      checkOutput($sformatf("vec%0d resp_data", i), 64'(d), 64'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d resp_flags", i), 64'(f), 64'(vecs[i].exp_flags));
      checkOutput($sformatf("vec%0d resp_id", i), 64'(rid), 64'(vecs[i].id));
      checkOutput($sformatf("vec%0d edges to resp_valid", i), 64'(e), 64'd2);
      checkOutput($sformatf("vec%0d strobe pulses", i), 64'(p), 64'd1);
      checkOutput($sformatf("vec%0d stray strobes", i), 64'(s), 64'd0);
    end

    $display("[TB] response held with resp_ready low");
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 2'd0; bus.req0_x = 8'h12; bus.req0_y = 8'h34;
    waitReady(1'b0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    waitResp();
    @(posedge clk); #1;
    bus.req1_valid = 1'b1; bus.req1_op = 2'd1; bus.req1_x = 8'h09; bus.req1_y = 8'h04;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall cycle %0d", k),
                  64'({bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_flags,
                       bus.req0_ready, bus.req1_ready,
                       bus.alu_dec, bus.alu_inc, bus.alu_sub, bus.alu_add}),
                  64'({1'b1, 1'b0, 8'h46, 5'b00000, 1'b0, 1'b0, 4'b0000}));
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    waitReady(1'b1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    waitResp();
    checkOutput("held-off req1 response",
                64'({bus.resp_id, bus.resp_data, bus.resp_flags}),
                64'({1'b1, 8'h05, 5'b00000}));

    $display("[TB] both requesters continuously valid");
    pulseReset();
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_op = 2'd2; bus.req0_x = 8'h7F; bus.req0_y = 8'h00;
    bus.req1_valid = 1'b1; bus.req1_op = 2'd3; bus.req1_x = 8'h80; bus.req1_y = 8'h00;
    nr = 0; ns = 0; prev = 1'b0;
    for (int j = 0; j < 4; j++) stb_at[j] = 0;
    for (int j = 0; j < 3; j++) got[j] = 14'd0;
    for (int n = 0; n < 40 && nr < 3; n++) begin
      @(negedge clk);
      cur = bus.alu_add | bus.alu_sub | bus.alu_inc | bus.alu_dec;
      if (cur && !prev && ns < 4) begin
        stb_at[ns] = n;
        ns++;
      end
      prev = cur;
      if (bus.resp_valid) begin
        got[nr] = {bus.resp_id, bus.resp_data, bus.resp_flags};
        nr++;
      end
    end
    checkOutput("alternating responses seen", 64'(nr), 64'd3);
    for (int j = 0; j < 3; j++)
      checkOutput($sformatf("alternating response %0d", j), 64'(got[j]),
                  (j == 1) ? 64'({1'b1, 8'h7F, 5'b11001}) : 64'({1'b0, 8'h80, 5'b11011}));
    checkOutput("strobe spacing 0-1", 64'(stb_at[1] - stb_at[0]), B2B ? 64'd3 : 64'd4);
    checkOutput("strobe spacing 1-2", 64'(stb_at[2] - stb_at[1]), B2B ? 64'd3 : 64'd4);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (6) @(posedge clk);

    $display("[TB] reset during WAIT");
    #1;
    bus.req0_valid = 1'b1; bus.req0_op = 2'd0; bus.req0_x = 8'h20; bus.req0_y = 8'h30;
    waitReady(1'b0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("outputs cleared by reset", 64'(outs()), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("no stale response %0d", k), 64'(outs()), 64'd0);
    end
    applyStimulus('{1'b0, 2'd0, 8'h01, 8'h01, 8'h02, 5'b00000}, d, f, rid, e, p, s);
    checkOutput("post-reset add data", 64'(d), 64'h02);
    checkOutput("post-reset add flags", 64'(f), 64'd0);
    checkOutput("post-reset add edges", 64'(e), 64'd2);
    checkOutput("post-reset add pulses", 64'(p), 64'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = ($urandom_range(0, 99) < 45);
        bus.req0_op    = 2'($urandom);
        bus.req0_x     = 8'($urandom);
        bus.req0_y     = 8'($urandom);
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = ($urandom_range(0, 99) < 45);
        bus.req1_op    = 2'($urandom);
        bus.req1_x     = 8'($urandom);
        bus.req1_y     = 8'($urandom);
      end
      bus.resp_ready = ($urandom_range(0, 99) < 70);
    end
    @(posedge clk); #1;
    if (!acc0) bus.req0_valid = bus.req0_valid;
    bus.resp_ready = 1'b1;
    while (bus.req0_valid || bus.req1_valid) begin
      @(negedge clk);
      @(posedge clk); #1;
      if (acc0) bus.req0_valid = 1'b0;
      if (acc1) bus.req1_valid = 1'b0;
      if (cyc > 5000) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
    repeat (8) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
